cloud_sprite_engine: RTL and testbench
======================================

CLOUD_SPRITE_ENGINE -- requirements
Module: cloud_sprite_engine

Interface
REQ-001 Parameter CLOUD_W, default 128, meaning sprite width in pixels (power of two).
REQ-002 Parameter CLOUD_H, default 71, meaning sprite height in pixels.
REQ-003 Parameter SCREEN_W, default 640, meaning visible line width; also the wrap re-entry X.
REQ-004 Parameter START_X, default 200, meaning cloud X after reset.
REQ-005 Parameter Y_POS, default 40, meaning fixed cloud top row.
REQ-006 Parameter SPEED, default 2, meaning pixels moved left per frame.
REQ-007 Port list, one per line: name, direction, width, meaning.
- Clk  input  1  single system clock; all logic on posedge.
- Reset  input  1  synchronous, active-high reset.
- frame_clk  input  1  vsync pulse, same clock domain; rising edge marks a new frame.
- pause  input  1  level; high freezes cloud motion.
- DrawX  input  10  current pixel column.
- DrawY  input  10  current pixel row.
- rom_addr  output  14  read address to the sprite ROM (128*71 = 9088 entries).
- rom_data  input  4  palette index from the ROM; valid one Clk after rom_addr.
- cloud_on  output  1  high when the aligned pixel is an opaque cloud pixel.
- cloud_idx  output  4  aligned palette index for the colour mapper.

Function
REQ-008 Position register cloud_x SHALL be signed 11 bits; Y SHALL be the constant Y_POS.
REQ-009 Frame edge SHALL be detected as frame_clk high and its 1-Clk-delayed copy low.
REQ-010 FSM states: RUN and HOLD. RUN->HOLD when pause=1 at a frame edge; HOLD->RUN when pause=0 at a frame edge; no other transitions.
REQ-011 In RUN, cloud_x SHALL update only on a frame edge: next = cloud_x - SPEED.
REQ-012 If next <= -CLOUD_W, cloud_x SHALL load SCREEN_W instead (wrap-around).
REQ-013 In HOLD, cloud_x SHALL not change.
REQ-014 Stage 1 SHALL compute hit = (DrawX - cloud_x) in [0, CLOUD_W-1] and (DrawY - Y_POS) in [0, CLOUD_H-1], using signed 11-bit compares.
REQ-015 Stage 1 SHALL register rom_addr = (DrawY-Y_POS)*CLOUD_W + (DrawX-cloud_x), implemented with a shift; rom_addr SHALL be 0 on a miss.
REQ-016 Stage 1 SHALL also register hit, which SHALL then be delayed one more Clk to align with rom_data.
REQ-017 Stage 2 SHALL register cloud_idx = rom_data and cloud_on = hit_aligned AND (rom_data != 0); index 0 is transparent.
REQ-018 Pixel-to-output latency SHALL be exactly 3 Clk: DrawX/DrawY sampled at edge k give outputs valid after edge k+2.
REQ-019 A partially off-screen cloud (cloud_x < 0 or cloud_x > SCREEN_W-CLOUD_W) SHALL draw only its on-screen columns, with no aliasing.
REQ-020 A position update and pixel lookup in the same Clk SHALL use the pre-update cloud_x.

Reset
REQ-021 Reset SHALL set cloud_x=START_X, state=RUN, frame edge register=0, rom_addr=0, all hit pipeline bits=0, cloud_on=0, cloud_idx=0.
REQ-022 Reset asserted mid-frame or mid-pipeline SHALL flush the pipeline, so cloud_on=0 on the first Clk after Reset deasserts.
REQ-023 A frame edge coincident with Reset SHALL be ignored.

Structure
REQ-024 Package cloud_pkg SHALL hold the default sprite and screen constants, the ADDR_W=14 and IDX_W=4 widths, and the state enum (RUN, HOLD).
REQ-025 The motion FSM plus wrap logic SHALL be one sub-module, sprite_pos_fsm; the ROM is instantiated by the parent, not inside this block.

Verification
REQ-026 Reset, then DrawX=200, DrawY=40 -> rom_addr=0 after 1 Clk; with ROM data 5, cloud_on=1 and cloud_idx=5 after 3 Clk.
REQ-027 DrawX=327, DrawY=110 -> rom_addr=9087. DrawX=328, DrawY=40 -> rom_addr=0; cloud_on=0 three Clk later.
REQ-028 ROM data 0 inside the box -> cloud_on=0 and cloud_idx=0.
REQ-029 Drive 100 frame edges with pause=0 -> cloud_x=0. Force cloud_x=-126, then one edge -> cloud_x=640.
REQ-030 pause=1 at frame edge 3, held for 5 edges -> cloud_x frozen at 194; after release, the next edge gives 192.
REQ-031 Assert Reset for 1 Clk during an active hit stream -> cloud_on=0 next Clk; cloud_x=200.

Source files
------------

// File: rtl/cloud_pkg.sv
// Shared constants, widths and motion-state encoding for the cloud sprite.
package cloud_pkg;
  localparam int CLOUD_W_D  = 128;
  localparam int CLOUD_H_D  = 71;
  localparam int SCREEN_W_D = 640;
  localparam int START_X_D  = 200;
  localparam int Y_POS_D    = 40;
  localparam int SPEED_D    = 2;

  localparam int ADDR_W = 14;   // 128*71 = 9088 ROM entries
  localparam int IDX_W  = 4;    // palette index width
  localparam int POS_W  = 11;   // signed screen coordinate width

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;
endpackage

// File: rtl/sprite_pos_fsm.sv
// Horizontal motion of the cloud: frame-edge detect, RUN/HOLD FSM, wrap-around.
module sprite_pos_fsm
  import cloud_pkg::*;
#(
  parameter int CLOUD_W  = CLOUD_W_D,
  parameter int SCREEN_W = SCREEN_W_D,
  parameter int START_X  = START_X_D,
  parameter int SPEED    = SPEED_D
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_clk,
  input  logic                    pause,
  output logic signed [POS_W-1:0] cloud_x,
  output state_e                  state
);
  localparam logic signed [POS_W-1:0] X0    = POS_W'(START_X);
  localparam logic signed [POS_W-1:0] STEP  = POS_W'(SPEED);
  localparam logic signed [POS_W-1:0] RE_X  = POS_W'(SCREEN_W);
  localparam logic signed [POS_W-1:0] NEG_W = POS_W'(-CLOUD_W);

  logic                    frame_q;
  logic                    frame_edge;
  logic signed [POS_W-1:0] next_x;

  assign frame_edge = frame_clk & ~frame_q;
  assign next_x     = cloud_x - STEP;

  // Once per frame: move left in RUN (re-entering from the right once the
  // sprite is fully off the left side); HOLD keeps the position untouched,
  // including on the edge that releases it back to RUN.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_q <= 1'b0;
      state   <= RUN;
      cloud_x <= X0;
    end else begin
      frame_q <= frame_clk;
      if (frame_edge) begin
        case (state)
          RUN: begin
            cloud_x <= (next_x <= NEG_W) ? RE_X : next_x;
            if (pause) state <= HOLD;
          end
          HOLD: if (!pause) state <= RUN;
          default: state <= RUN;
        endcase
      end
    end
  end
endmodule

// File: rtl/cloud_sprite_engine.sv
// Cloud sprite: position FSM plus a 3-Clk hit/ROM-lookup pixel pipeline.
module cloud_sprite_engine
  import cloud_pkg::*;
#(
  parameter int CLOUD_W  = CLOUD_W_D,
  parameter int CLOUD_H  = CLOUD_H_D,
  parameter int SCREEN_W = SCREEN_W_D,
  parameter int START_X  = START_X_D,
  parameter int Y_POS    = Y_POS_D,
  parameter int SPEED    = SPEED_D
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic              pause,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_data,
  output logic              cloud_on,
  output logic [IDX_W-1:0]  cloud_idx
);
  localparam int LOG2W = $clog2(CLOUD_W);
  localparam logic signed [POS_W-1:0] W_S = POS_W'(CLOUD_W);
  localparam logic signed [POS_W-1:0] H_S = POS_W'(CLOUD_H);
  localparam logic signed [POS_W-1:0] Y_S = POS_W'(Y_POS);

  logic signed [POS_W-1:0] cloud_x;
  state_e                  pos_state;
  logic signed [POS_W-1:0] dx, dy;
  logic                    hit_c;
  logic [ADDR_W-1:0]       addr_c;
  logic [1:0]              hit_pipe;   // [0] with rom_addr, [1] with rom_data

  sprite_pos_fsm #(
    .CLOUD_W (CLOUD_W),
    .SCREEN_W(SCREEN_W),
    .START_X (START_X),
    .SPEED   (SPEED)
  ) u_pos (
    .Clk      (Clk),
    .Reset    (Reset),
    .frame_clk(frame_clk),
    .pause    (pause),
    .cloud_x  (cloud_x),
    .state    (pos_state)
  );

  // Box test in signed 11-bit: negative offsets (left of / above the sprite)
  // and large wrapped offsets both land outside [0, W-1], so off-screen
  // parts of the sprite never alias onto visible columns.
  always_comb begin
    dx     = $signed({1'b0, DrawX}) - cloud_x;
    dy     = $signed({1'b0, DrawY}) - Y_S;
    hit_c  = !dx[POS_W-1] && (dx < W_S) && !dy[POS_W-1] && (dy < H_S);
    addr_c = '0;
    if (hit_c)
      addr_c = (ADDR_W'(dy) << LOG2W) | ADDR_W'(dx[LOG2W-1:0]);
  end

  // Stage 1 registers address/hit, hit is delayed to meet rom_data, stage 2
  // registers the palette index and opacity.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr  <= '0;
      hit_pipe  <= '0;
      cloud_on  <= 1'b0;
      cloud_idx <= '0;
    end else begin
      rom_addr  <= addr_c;
      hit_pipe  <= {hit_pipe[0], hit_c};
      cloud_idx <= rom_data;
      cloud_on  <= hit_pipe[1] & (rom_data != '0);
    end
  end
endmodule

// File: tb/tb_cloud_sprite_engine.sv
// Directed bench for cloud_sprite_engine with a synchronous ROM model.
module tb_cloud_sprite_engine;
  import cloud_pkg::*;

  logic              Clk = 1'b0;
  logic              Reset, frame_clk, pause;
  logic [9:0]        DrawX, DrawY;
  logic [ADDR_W-1:0] rom_addr;
  logic [IDX_W-1:0]  rom_data;
  logic              cloud_on;
  logic [IDX_W-1:0]  cloud_idx;

  logic [IDX_W-1:0]  rom_mem [0:16383];
  int checks = 0;
  int passes = 0;

  cloud_sprite_engine dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .frame_clk(frame_clk),
    .pause    (pause),
    .DrawX    (DrawX),
    .DrawY    (DrawY),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .cloud_on (cloud_on),
    .cloud_idx(cloud_idx)
  );

  always #5 Clk = ~Clk;

  // Sprite ROM: one Clk read latency.
  always @(posedge Clk) rom_data <= rom_mem[rom_addr];

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic frame_edge();
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    step();
  endtask

  task automatic test_reset();
    Reset = 1'b1; frame_clk = 1'b0; pause = 1'b0; DrawX = 10'd0; DrawY = 10'd0;
    step(3);
    checks++; if (rom_addr !== 14'd0) $display("FAIL reset_addr got %0d want 0", rom_addr); else passes++;
    checks++; if (cloud_on !== 1'b0) $display("FAIL reset_on got %b want 0", cloud_on); else passes++;
    checks++; if (cloud_idx !== 4'd0) $display("FAIL reset_idx got %0d want 0", cloud_idx); else passes++;
    checks++; if (dut.cloud_x !== 11'sd200) $display("FAIL reset_x got %0d want 200", dut.cloud_x); else passes++;
    checks++; if (dut.u_pos.state !== RUN) $display("FAIL reset_state got %0d want RUN", dut.u_pos.state); else passes++;
    Reset = 1'b0;
    step();
  endtask

  task automatic test_hit_origin();
    DrawX = 10'd200; DrawY = 10'd40;
    step();
    checks++; if (rom_addr !== 14'd0) $display("FAIL origin_addr got %0d want 0", rom_addr); else passes++;
    step(2);
    checks++; if (cloud_on !== 1'b1) $display("FAIL origin_on got %b want 1", cloud_on); else passes++;
    checks++; if (cloud_idx !== 4'd5) $display("FAIL origin_idx got %0d want 5", cloud_idx); else passes++;
  endtask

  task automatic test_box_edges();
    logic [9:0] mx [4] = '{10'd199, 10'd200, 10'd200, 10'd328};
    logic [9:0] my [4] = '{10'd40,  10'd39,  10'd111, 10'd40};
    DrawX = 10'd327; DrawY = 10'd110;
    step();
    checks++; if (rom_addr !== 14'd9087) $display("FAIL corner_addr got %0d want 9087", rom_addr); else passes++;
    step(2);
    checks++; if (cloud_on !== 1'b1 || cloud_idx !== 4'hA)
      $display("FAIL corner_out got on=%b idx=%0d want on=1 idx=10", cloud_on, cloud_idx); else passes++;
    for (int i = 0; i < 4; i++) begin
      DrawX = mx[i]; DrawY = my[i];
      step();
      checks++; if (rom_addr !== 14'd0) $display("FAIL miss%0d_addr got %0d want 0", i, rom_addr); else passes++;
      step(2);
      checks++; if (cloud_on !== 1'b0) $display("FAIL miss%0d_on got %b want 0", i, cloud_on); else passes++;
    end
  endtask

  task automatic test_transparent();
    DrawX = 10'd210; DrawY = 10'd50;
    step();
    checks++; if (rom_addr !== 14'd1290) $display("FAIL transp_addr got %0d want 1290", rom_addr); else passes++;
    step(2);
    checks++; if (cloud_on !== 1'b0 || cloud_idx !== 4'd0)
      $display("FAIL transp_out got on=%b idx=%0d want on=0 idx=0", cloud_on, cloud_idx); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] xs   [4] = '{10'd326, 10'd327, 10'd328, 10'd329};
    logic       eon  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] eidx [4] = '{4'd3, 4'd7, 4'd5, 4'd5};
    DrawY = 10'd41;
    for (int t = 0; t < 6; t++) begin
      if (t < 4) DrawX = xs[t];
      step();
      if (t >= 2) begin
        checks++;
        if (cloud_on !== eon[t-2] || cloud_idx !== eidx[t-2])
          $display("FAIL b2b%0d got on=%b idx=%0d want on=%b idx=%0d",
                   t-2, cloud_on, cloud_idx, eon[t-2], eidx[t-2]);
        else passes++;
      end
    end
  endtask

  task automatic test_motion_wrap();
    DrawX = 10'd0; DrawY = 10'd0;
    for (int i = 0; i < 100; i++) frame_edge();
    checks++; if (dut.cloud_x !== 11'sd0) $display("FAIL move100 got %0d want 0", dut.cloud_x); else passes++;
    for (int i = 0; i < 63; i++) frame_edge();
    checks++; if (dut.cloud_x !== 11'(-126)) $display("FAIL move163 got %0d want -126", dut.cloud_x); else passes++;
    // Left edge partly off-screen: only columns 0 and 1 are visible.
    DrawY = 10'd40;
    DrawX = 10'd0; step();
    checks++; if (rom_addr !== 14'd126) $display("FAIL off0_addr got %0d want 126", rom_addr); else passes++;
    DrawX = 10'd1; step();
    checks++; if (rom_addr !== 14'd127) $display("FAIL off1_addr got %0d want 127", rom_addr); else passes++;
    DrawX = 10'd2; step();
    checks++; if (rom_addr !== 14'd0) $display("FAIL off2_addr got %0d want 0", rom_addr); else passes++;
    checks++; if (cloud_on !== 1'b1 || cloud_idx !== 4'h9)
      $display("FAIL off0_out got on=%b idx=%0d want on=1 idx=9", cloud_on, cloud_idx); else passes++;
    DrawX = 10'd1023; step();
    checks++; if (rom_addr !== 14'd0) $display("FAIL alias_addr got %0d want 0", rom_addr); else passes++;
    checks++; if (cloud_on !== 1'b1 || cloud_idx !== 4'h6)
      $display("FAIL off1_out got on=%b idx=%0d want on=1 idx=6", cloud_on, cloud_idx); else passes++;
    step();
    checks++; if (cloud_on !== 1'b0) $display("FAIL off2_on got %b want 0", cloud_on); else passes++;
    frame_edge();
    checks++; if (dut.cloud_x !== 11'sd640) $display("FAIL wrap got %0d want 640", dut.cloud_x); else passes++;
    // Lookup on the same Clk as a move sees the old position (640).
    DrawX = 10'd641; DrawY = 10'd41; frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    checks++; if (rom_addr !== 14'd129) $display("FAIL same_clk_addr got %0d want 129", rom_addr); else passes++;
    checks++; if (dut.cloud_x !== 11'sd638) $display("FAIL same_clk_x got %0d want 638", dut.cloud_x); else passes++;
    step();
  endtask

  task automatic test_pause();
    Reset = 1'b1; step(); Reset = 1'b0; step();
    frame_edge(); frame_edge();
    checks++; if (dut.cloud_x !== 11'sd196) $display("FAIL pre_pause got %0d want 196", dut.cloud_x); else passes++;
    pause = 1'b1;
    frame_edge();
    checks++; if (dut.cloud_x !== 11'sd194 || dut.u_pos.state !== HOLD)
      $display("FAIL pause_edge got x=%0d st=%0d want x=194 st=HOLD", dut.cloud_x, dut.u_pos.state); else passes++;
    for (int i = 0; i < 4; i++) frame_edge();
    checks++; if (dut.cloud_x !== 11'sd194) $display("FAIL held got %0d want 194", dut.cloud_x); else passes++;
    pause = 1'b0;
    frame_edge();
    checks++; if (dut.cloud_x !== 11'sd194 || dut.u_pos.state !== RUN)
      $display("FAIL release got x=%0d st=%0d want x=194 st=RUN", dut.cloud_x, dut.u_pos.state); else passes++;
    frame_edge();
    checks++; if (dut.cloud_x !== 11'sd192) $display("FAIL resume got %0d want 192", dut.cloud_x); else passes++;
  endtask

  task automatic test_reset_mid_stream();
    // Cloud at 192: box spans X 192..319.
    DrawX = 10'd200; DrawY = 10'd40;
    step(3);
    checks++; if (cloud_on !== 1'b1) $display("FAIL stream_on got %b want 1", cloud_on); else passes++;
    Reset = 1'b1; frame_clk = 1'b1;
    step();
    Reset = 1'b0; frame_clk = 1'b0;
    checks++; if (cloud_on !== 1'b0 || dut.cloud_x !== 11'sd200)
      $display("FAIL midrst got on=%b x=%0d want on=0 x=200", cloud_on, dut.cloud_x); else passes++;
    step();
    checks++; if (cloud_on !== 1'b0 || dut.cloud_x !== 11'sd200)
      $display("FAIL postrst got on=%b x=%0d want on=0 x=200", cloud_on, dut.cloud_x); else passes++;
    step(2);
    checks++; if (cloud_on !== 1'b1 || cloud_idx !== 4'd5)
      $display("FAIL refill got on=%b idx=%0d want on=1 idx=5", cloud_on, cloud_idx); else passes++;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) rom_mem[i] = 4'((i % 15) + 1);
    rom_mem[0]    = 4'd5;
    rom_mem[9087] = 4'hA;
    rom_mem[1290] = 4'd0;
    rom_mem[254]  = 4'd3;
    rom_mem[255]  = 4'd7;
    rom_mem[126]  = 4'h9;
    rom_mem[127]  = 4'h6;
    test_reset();
    test_hit_origin();
    test_box_edges();
    test_transparent();
    test_back_to_back();
    test_motion_wrap();
    test_pause();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
